// File: rtl/dmem_responder.sv
//==============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data-memory responder for the pipelined MIPS core.
//               Latches an M-stage load/store, stalls the pipeline for LAT+1
//               cycles, then completes the access against a byte-lane RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
    parameter int AW  = 10,
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memen,
    input  logic        memwrite,
    input  logic [3:0]  wbe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_CNT_INIT = 4'(LAT - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [3:0]    r_wbe;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_addrErr;

    logic [31:0]   r_mem [0:(1<<AW)-1];

    logic [AW-1:0] w_idx;
    logic          w_misaligned;
    logic          w_complete;
    logic          w_memWrite;
    logic          w_unusedAddr;

    // Upper address bits are dropped on purpose so accesses wrap.
    assign w_unusedAddr = ^addr[31:AW+2];

    assign w_idx        = r_addr[AW+1:2];
    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_complete   = (r_state == c_BUSY) && (r_cnt == 4'd0);
    assign w_memWrite   = !rst && w_complete && r_write && !w_misaligned;

    assign stall    = ((r_state == c_IDLE) && memen) || (r_state == c_BUSY);
    assign rdata    = r_rdata;
    assign addr_err = r_addrErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_wbe     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_addrErr <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (memen) begin
                        r_write <= memwrite;
                        r_wbe   <= wbe;
                        r_addr  <= addr[AW+1:0];
                        r_wdata <= wdata;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_addrErr <= w_misaligned;
                        if (!r_write) begin
                            r_rdata <= w_misaligned ? 32'd0 : r_mem[w_idx];
                        end
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // The request still held on memen here is the one just served.
                    r_addrErr <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_addrErr <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

    // RAM is never reset; writes are gated by rst so an interrupted store is dropped.
    always_ff @(posedge clk) begin
        if (w_memWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wbe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder (LAT=2 and LAT=1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        memen = 1'b0;
    logic        memwrite = 1'b0;
    logic [3:0]  wbe = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        addrErr;

    logic        memen1 = 1'b0;
    logic        memwrite1 = 1'b0;
    logic [3:0]  wbe1 = 4'd0;
    logic [31:0] addr1 = 32'd0;
    logic [31:0] wdata1 = 32'd0;
    logic [31:0] rdata1;
    logic        stall1;
    logic        addrErr1;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.AW(10), .LAT(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .memen    (memen),
        .memwrite (memwrite),
        .wbe      (wbe),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .addr_err (addrErr)
    );

    dmem_responder #(.AW(10), .LAT(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .memen    (memen1),
        .memwrite (memwrite1),
        .wbe      (wbe1),
        .addr     (addr1),
        .wdata    (wdata1),
        .rdata    (rdata1),
        .stall    (stall1),
        .addr_err (addrErr1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request on the LAT=2 instance, entered just after a rising edge.
    task automatic doAccess(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic chkData, input logic [31:0] expData,
                            input logic expErr);
        int  nStall = 0;
        bit  done   = 1'b0;
        memen = 1'b1; memwrite = we; wbe = be; addr = a; wdata = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall) nStall++;
            else       done = 1'b1;
        end
        chk({tag, ".stallCycles"}, nStall, 32'd3);
        if (chkData) chk({tag, ".rdata"}, rdata, expData);
        chk({tag, ".addrErr"}, {31'd0, addrErr}, {31'd0, expErr});
        @(posedge clk); #1;
        memen = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        chk({tag, ".addrErrOff"}, {31'd0, addrErr}, 32'd0);
        chk({tag, ".idleStall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.addrErr", {31'd0, addrErr}, 32'd0);
        chk("rst.stallIdle", {31'd0, stall}, 32'd0);
        memen = 1'b1; #1;
        chk("rst.stallMemen", {31'd0, stall}, 32'd1);
        memen = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // 1: store then load
        doAccess("t1.st", 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        doAccess("t1.ld", 1'b0, 4'h0, 32'h40, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);

        // 2: partial byte-lane store
        doAccess("t2.pre", 1'b1, 4'hF, 32'h80, 32'h11223344, 1'b0, 32'd0, 1'b0);
        doAccess("t2.st", 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD, 1'b1, 32'hDEADBEEF, 1'b0);
        doAccess("t2.ld", 1'b0, 4'h0, 32'h80, 32'd0, 1'b1, 32'h11BB33DD, 1'b0);

        // 3: misaligned load and store
        doAccess("t3.ldMis", 1'b0, 4'h0, 32'h42, 32'd0, 1'b1, 32'd0, 1'b1);
        doAccess("t3.stMis", 1'b1, 4'hF, 32'h42, 32'h12345678, 1'b0, 32'd0, 1'b1);
        doAccess("t3.ld", 1'b0, 4'h0, 32'h40, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);

        // 4: address wrap and wbe=0 no-op store
        doAccess("t4.st", 1'b1, 4'hF, 32'h1004, 32'h5, 1'b0, 32'd0, 1'b0);
        doAccess("t4.nop", 1'b1, 4'h0, 32'h4, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0);
        doAccess("t4.ld", 1'b0, 4'h0, 32'h0004, 32'd0, 1'b1, 32'h5, 1'b0);

        // 5: reset during a pending store
        doAccess("t5.pre", 1'b1, 4'hF, 32'h10, 32'h0, 1'b1, 32'h5, 1'b0);
        memen = 1'b1; memwrite = 1'b1; wbe = 4'hF; addr = 32'h10; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t5.stallIdle", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("t5.stallBusy", {31'd0, stall}, 32'd1);
        rst = 1'b1; #1;
        chk("t5.rdata", rdata, 32'd0);
        chk("t5.stallRst", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; memen = 1'b0; memwrite = 1'b0;
        @(negedge clk);
        chk("t5.stallAfter", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        doAccess("t5.ld", 1'b0, 4'h0, 32'h10, 32'd0, 1'b1, 32'h0, 1'b0);

        // 6: LAT=1, memen held across three back-to-back stores
        memen1 = 1'b1; memwrite1 = 1'b1; wbe1 = 4'hF; addr1 = 32'h20; wdata1 = 32'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t6.stall", {31'd0, stall1}, {31'd0, (i % 3) != 2});
            if ((i % 3) == 2) begin
                @(posedge clk); #1;
                addr1 = addr1 + 32'd4;
                wdata1 = wdata1 + 32'd1;
                if (i == 8) memen1 = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6.noFourth", {31'd0, stall1}, 32'd0);
        end
        @(posedge clk); #1;
        memen1 = 1'b1; memwrite1 = 1'b0; addr1 = 32'h28;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t6.ld3.stall", {31'd0, stall1}, 32'd0);
        chk("t6.ld3", rdata1, 32'd3);
        @(posedge clk); #1;
        addr1 = 32'h20;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t6.ld1", rdata1, 32'd1);
        @(posedge clk); #1;
        addr1 = 32'h24;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("t6.ld2", rdata1, 32'd2);
        @(posedge clk); #1;
        memen1 = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
